trng_seed_buf: RTL and testbench

TRNG_SEED_BUF -- requirements
Module: trng_seed_buf

---
 rtl/trng_seed_buf.sv | 179 +++++++++++++++++
 tb/tb_trng_seed_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_seed_buf.sv
// trng_seed_buf: collects raw TRNG bits into a 256-bit seed buffer.
//
// Raw bits pass through an optional von Neumann debiaser. A repetition-count
// health test runs on the raw stream. Once 256 accepted bits are held, the
// buffer is presented as full until the consumer reads it.
//
// Ports:
//   clk            in   clock, rising edge
//   rstn           in   asynchronous active-low reset
//   buf_en         in   block enable; low forces IDLE and clears content
//   flush          in   one-cycle pulse, discards the buffer content
//   vn_en          in   von Neumann debias enable (static while buf_en=1)
//   digi_data_out  in   raw noise bit
//   digi_data_vld  in   raw bit qualifier
//   post_read      in   consumer read strobe (acts only while full)
//   health_err_clr in   clears health_err and leaves ERR
//   buf_data       out  256-bit collected entropy, newest bit in bit 0
//   buf_ready      out  buffer full and valid
//   fill_cnt       out  number of bits held, 0..256
//   health_err     out  sticky repetition-count failure flag
module trng_seed_buf #(
  parameter logic [5:0] RCT_LIMIT = 6'd32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         buf_en,
  input  logic         flush,
  input  logic         vn_en,
  input  logic         digi_data_out,
  input  logic         digi_data_vld,
  input  logic         post_read,
  input  logic         health_err_clr,
  output logic [255:0] buf_data,
  output logic         buf_ready,
  output logic [8:0]   fill_cnt,
  output logic         health_err
);

  typedef enum logic [1:0] {IDLE, FILL, FULL, ERR} state_t;

  state_t       state_q, state_d;
  logic [255:0] buf_q, buf_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         pend_q, pend_d;   // von Neumann: first bit of a pair stored
  logic         pbit_q, pbit_d;   // the stored first bit
  logic [5:0]   run_q, run_d;     // repetition run length, 0 = no history
  logic         last_q, last_d;
  logic         herr_q, herr_d;

  logic         sample;
  logic [5:0]   run_inc;
  logic         trip;
  logic         acc;
  logic         acc_bit;
  logic         vn_pend;
  logic         vn_pbit;

  always_comb begin
    // Raw bits only enter the health test and debiaser while collecting.
    sample = digi_data_vld && (state_q == FILL || state_q == FULL);

    if (run_q == 6'd0) begin
      run_inc = 6'd1;
    end else if (digi_data_out == last_q) begin
      run_inc = (run_q == RCT_LIMIT) ? run_q : run_q + 6'd1;
    end else begin
      run_inc = 6'd1;
    end
    trip = sample && (run_inc == RCT_LIMIT);

    // Debiaser: 01 -> 0, 10 -> 1, i.e. emit the first bit of a differing pair.
    acc     = 1'b0;
    acc_bit = digi_data_out;
    vn_pend = pend_q;
    vn_pbit = pbit_q;
    if (sample) begin
      if (!vn_en) begin
        acc = 1'b1;
      end else if (!pend_q) begin
        vn_pend = 1'b1;
        vn_pbit = digi_data_out;
      end else begin
        vn_pend = 1'b0;
        acc     = (pbit_q != digi_data_out);
        acc_bit = pbit_q;
      end
    end

    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pbit_d  = pbit_q;
    run_d   = run_q;
    last_d  = last_q;
    herr_d  = herr_q;

    if (!buf_en) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      run_d   = '0;
    end else if (flush) begin
      buf_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      run_d   = '0;
      state_d = (state_q == ERR) ? ERR : FILL;
    end else begin
      case (state_q)
        IDLE: state_d = FILL;
        ERR: begin
          if (health_err_clr) begin
            herr_d  = 1'b0;
            run_d   = '0;
            state_d = FILL;
          end
        end
        default: begin
          if (sample) begin
            run_d  = run_inc;
            last_d = digi_data_out;
          end
          if (trip) begin
            state_d = ERR;
            herr_d  = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            // Pairing continues while full so the debiaser stays aligned.
            pend_d = vn_pend;
            pbit_d = vn_pbit;
            if (post_read && state_q == FULL) begin
              buf_d   = '0;
              cnt_d   = '0;
              state_d = FILL;
            end else if (acc && state_q == FILL) begin
              buf_d = {buf_q[254:0], acc_bit};
              cnt_d = cnt_q + 9'd1;
              if (cnt_q == 9'd255) begin
                state_d = FULL;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pbit_q  <= 1'b0;
      run_q   <= '0;
      last_q  <= 1'b0;
      herr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pbit_q  <= pbit_d;
      run_q   <= run_d;
      last_q  <= last_d;
      herr_q  <= herr_d;
    end
  end

  assign buf_data   = buf_q;
  assign buf_ready  = (state_q == FULL);
  assign fill_cnt   = cnt_q;
  assign health_err = herr_q;

endmodule

// File: tb/tb_trng_seed_buf.sv
// tb_trng_seed_buf: scoreboard bench for trng_seed_buf.
// Each driven cycle updates a transaction-level reference model and pushes
// the expected outputs; after the clock edge the entry is popped and compared.
module tb_trng_seed_buf;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         buf_en = 1'b0;
  logic         flush = 1'b0;
  logic         vn_en = 1'b0;
  logic         digi_data_out = 1'b0;
  logic         digi_data_vld = 1'b0;
  logic         post_read = 1'b0;
  logic         health_err_clr = 1'b0;
  logic [255:0] buf_data;
  logic         buf_ready;
  logic [8:0]   fill_cnt;
  logic         health_err;

  trng_seed_buf dut (
    .clk(clk), .rstn(rstn), .buf_en(buf_en), .flush(flush), .vn_en(vn_en),
    .digi_data_out(digi_data_out), .digi_data_vld(digi_data_vld),
    .post_read(post_read), .health_err_clr(health_err_clr),
    .buf_data(buf_data), .buf_ready(buf_ready), .fill_cnt(fill_cnt),
    .health_err(health_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rdy;
    logic [8:0]   cnt;
    logic         herr;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 IDLE, 1 FILL, 2 FULL, 3 ERR
  int           m_st;
  logic [255:0] m_buf;
  int           m_cnt;
  logic         m_pend, m_pbit, m_last, m_herr;
  int           m_run;

  logic [255:0] pat_aa;
  logic [255:0] tmp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_buf = '0; m_cnt = 0; m_pend = 0; m_pbit = 0;
    m_last = 0; m_herr = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic en, fl, vn, d, v, rd, clr);
    logic emit, ebit;
    emit = 0; ebit = 0;
    if (!en) begin
      m_st = 0; m_buf = '0; m_cnt = 0; m_pend = 0; m_run = 0;
    end else if (fl) begin
      m_buf = '0; m_cnt = 0; m_pend = 0; m_run = 0;
      if (m_st != 3) m_st = 1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 3) begin
      if (clr) begin m_herr = 0; m_run = 0; m_st = 1; end
    end else begin
      if (v) begin
        if (m_run == 0 || d != m_last) m_run = 1;
        else if (m_run < 32) m_run = m_run + 1;
        m_last = d;
      end
      if (v && m_run == 32) begin
        m_st = 3; m_herr = 1; m_buf = '0; m_cnt = 0; m_pend = 0;
      end else begin
        if (v) begin
          if (!vn) begin emit = 1; ebit = d; end
          else if (!m_pend) begin m_pend = 1; m_pbit = d; end
          else begin
            m_pend = 0;
            if (m_pbit != d) begin emit = 1; ebit = m_pbit; end
          end
        end
        if (rd && m_st == 2) begin
          m_buf = '0; m_cnt = 0; m_st = 1;
        end else if (emit && m_st == 1) begin
          m_buf = {m_buf[254:0], ebit};
          m_cnt = m_cnt + 1;
          if (m_cnt == 256) m_st = 2;
        end
      end
    end
  endtask

  task automatic step(input logic en, fl, vn, d, v, rd, clr);
    exp_t e, got;
    buf_en = en; flush = fl; vn_en = vn; digi_data_out = d;
    digi_data_vld = v; post_read = rd; health_err_clr = clr;
    model_edge(en, fl, vn, d, v, rd, clr);
    e.rdy = (m_st == 2); e.cnt = 9'(m_cnt); e.herr = m_herr; e.data = m_buf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("buf_ready", 256'(buf_ready), 256'(got.rdy));
    chk("fill_cnt", 256'(fill_cnt), 256'(got.cnt));
    chk("health_err", 256'(health_err), 256'(got.herr));
    chk("buf_data", buf_data, got.data);
    flush = 0; post_read = 0; health_err_clr = 0; digi_data_vld = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, buf_data, '0);
    chk({tag, "_ready"}, 256'(buf_ready), '0);
    chk({tag, "_cnt"}, 256'(fill_cnt), '0);
    chk({tag, "_herr"}, 256'(health_err), '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] vn_raw;
    pat_aa = {128{2'b10}};
    vn_raw = 10'b0110001110;
    model_reset();

    // Reset state
    #12;
    check_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // IDLE -> FILL, then 256 alternating bits starting with 1
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(1, 0, 0, ~i[0], 1, 0, 0);
    chk("full_data", buf_data, pat_aa);
    chk("full_cnt", 256'(fill_cnt), 256'd256);
    chk("full_ready", 256'(buf_ready), 256'd1);

    // Bits in FULL dropped, then read strobe together with a valid bit
    for (int i = 0; i < 4; i++) step(1, 0, 0, ~i[0], 1, 0, 0);
    post_read = 1; digi_data_vld = 1; #1;
    chk("strobe_data", buf_data, pat_aa);
    step(1, 0, 0, 1, 1, 1, 0);
    chk("read_cnt", 256'(fill_cnt), '0);
    chk("read_ready", 256'(buf_ready), '0);
    for (int i = 0; i < 300; i++) step(1, 0, 0, ~i[0], 1, 0, 0);
    chk("refill_ready", 256'(buf_ready), 256'd1);

    // Von Neumann: 01,10,00,11,10
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 9; i >= 0; i--) step(1, 0, 1, vn_raw[i], 1, 0, 0);
    chk("vn_cnt", 256'(fill_cnt), 256'd3);
    tmp = buf_data;
    chk("vn_bits", 256'(tmp[2:0]), 256'd3);

    // Repetition count trip, ignored bits, clear
    for (int i = 0; i < 32; i++) step(1, 0, 1, 1, 1, 0, 0);
    chk("rct_herr", 256'(health_err), 256'd1);
    chk("rct_cnt", 256'(fill_cnt), '0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, i[0], 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);   // flush while in ERR keeps ERR
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1);
    chk("clr_herr", 256'(health_err), '0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0);
    chk("clr_fill", 256'(fill_cnt), 256'd1);

    // Flush at 100, reset at 200
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, i[0], 1, 0, 0);
    chk("pre_flush_cnt", 256'(fill_cnt), 256'd100);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("flush_cnt", 256'(fill_cnt), '0);
    chk("flush_data", buf_data, '0);
    for (int i = 0; i < 200; i++) step(1, 0, 0, i[0], 1, 0, 0);
    chk("pre_rst_cnt", 256'(fill_cnt), 256'd200);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;

    // Random traffic, including strobes and clears outside their states
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 700; i++) begin
      step(1, ($urandom_range(0, 99) == 0), 0, 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
